// File: rtl/timer_alarm_sched.sv
// timer_alarm_sched: sequences a shared 64-bit timer core and raises sticky per-channel alarm irqs
module timer_alarm_sched #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_op,
  input  logic [2*DATA_W-1:0] cfg_deadline,
  input  logic [2*DATA_W-1:0] cfg_period,
  input  logic [N_CH-1:0]     irq_clr,
  output logic                timer_enable,
  output logic                timer_sample,
  input  logic [2*DATA_W-1:0] timer_value,
  output logic [2*DATA_W-1:0] now,
  output logic [N_CH-1:0]     armed,
  output logic [N_CH-1:0]     irq,
  output logic                irq_any
);
  localparam int TW = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, SAMPLE, LATCH, SCAN} state_t;
  state_t state, state_nx;
  logic [CH_W-1:0] idx;
  logic [TW-1:0]   deadline [N_CH];
  logic [TW-1:0]   period   [N_CH];
  logic [N_CH-1:0] periodic;
  logic [N_CH-1:0] fire_vec;
  logic            fire, cfg_acc;
  always_comb begin
    state_nx = !en ? IDLE :
               state == IDLE   ? SAMPLE :
               state == SAMPLE ? LATCH :
               state == LATCH  ? SCAN :
               idx == CH_W'(N_CH - 1) ? SAMPLE : SCAN;
    fire     = state == SCAN && en && armed[idx] && now >= deadline[idx];
    fire_vec = fire ? N_CH'(1) << idx : '0;
    cfg_acc  = cfg_valid && cfg_ready;
  end
  assign cfg_ready    = state != SCAN;
  assign timer_enable = en;
  assign timer_sample = state == SAMPLE;
  assign irq_any      = |irq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      now      <= '0;
      armed    <= '0;
      irq      <= '0;
      periodic <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deadline[i] <= '0;
        period[i]   <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= (state == SCAN && state_nx == SCAN) ? idx + 1'b1 : '0;
      if (state == LATCH && en) now <= timer_value;
      // a fire on the same edge as a clear keeps the flag set
      irq <= (irq & ~irq_clr) | fire_vec;
      if (fire) begin
        if (periodic[idx] && period[idx] != '0) deadline[idx] <= deadline[idx] + period[idx];
        else armed[idx] <= 1'b0;
      end
      if (cfg_acc && cfg_op != 2'b11) armed[cfg_ch] <= cfg_op != 2'b00;
      if (cfg_acc && (cfg_op[0] ^ cfg_op[1])) begin
        deadline[cfg_ch] <= cfg_deadline;
        period[cfg_ch]   <= cfg_period;
        periodic[cfg_ch] <= cfg_op[1];
      end
    end
  end
endmodule
